// File: rtl/seg_scan_capture_if.sv
// Bus bundle between a 7-segment display scanner and the frame capture block.
// The master drives the display lines and frame_ready; the slave (capture) returns frames.
interface seg_scan_capture_if #(
  parameter int DIGITS = 4
) ();
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_en;
  logic [4*DIGITS-1:0] frame_bcd;
  logic [DIGITS-1:0]   frame_blank;
  logic [DIGITS-1:0]   frame_err;
  logic                frame_valid;
  logic                frame_ready;
  logic                overrun;
  logic                frame_abort;

  modport master (
    output seg_in, dig_en, frame_ready,
    input  frame_bcd, frame_blank, frame_err, frame_valid, overrun, frame_abort
  );

  modport slave (
    input  seg_in, dig_en, frame_ready,
    output frame_bcd, frame_blank, frame_err, frame_valid, overrun, frame_abort
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 7-segment display into BCD frames: debounce each digit,
// decode it into a shadow slot, and hand complete frames out over valid/ready.
module seg_scan_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input logic clk,
  input logic rst_n,
  seg_scan_capture_if.slave bus
);

  localparam logic [7:0]  STABLE_L = 8'(STABLE_CNT);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  // Returns {err, blank, nibble} for one segment pattern (bit6=a .. bit0=g).
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'b1111110: res = {2'b00, 4'd0};
      7'b0110000: res = {2'b00, 4'd1};
      7'b1101101: res = {2'b00, 4'd2};
      7'b1111001: res = {2'b00, 4'd3};
      7'b0110011: res = {2'b00, 4'd4};
      7'b1011011: res = {2'b00, 4'd5};
      7'b1011111: res = {2'b00, 4'd6};
      7'b1110000: res = {2'b00, 4'd7};
      7'b1111111: res = {2'b00, 4'd8};
      7'b1111011: res = {2'b00, 4'd9};
      7'b0000000: res = {2'b01, 4'd0};
      default:    res = {2'b10, 4'hF};
    endcase
    return res;
  endfunction

  state_t                state_r;
  logic [DIGITS+6:0]     prev_r;
  logic [7:0]            cnt_r;
  logic [15:0]           tmo_r;
  logic [DIGITS-1:0]     captured_r;
  logic [4*DIGITS-1:0]   shd_bcd_r;
  logic [DIGITS-1:0]     shd_blank_r;
  logic [DIGITS-1:0]     shd_err_r;
  logic [4*DIGITS-1:0]   frame_bcd_r;
  logic [DIGITS-1:0]     frame_blank_r;
  logic [DIGITS-1:0]     frame_err_r;
  logic                  valid_r;
  logic                  overrun_r;
  logic                  abort_r;

  logic [DIGITS+6:0]     sample_s;
  logic                  onehot_s;
  logic                  same_s;
  logic [7:0]            cnt_nxt_s;
  logic                  capture_s;
  logic [5:0]            dec_s;
  logic [4*DIGITS-1:0]   shd_bcd_nxt_s;
  logic [DIGITS-1:0]     shd_blank_nxt_s;
  logic [DIGITS-1:0]     shd_err_nxt_s;
  logic [DIGITS-1:0]     cap_nxt_s;
  logic                  complete_s;
  logic                  handshake_s;
  logic                  tmo_hit_s;

  // Debounce, decode and shadow-slot update for the current sample.
  always_comb begin
    sample_s = {bus.dig_en, bus.seg_in};
    onehot_s = $onehot(bus.dig_en);
    same_s   = (sample_s == prev_r);
    if (!onehot_s) begin
      cnt_nxt_s = 8'd0;
    end else if (same_s) begin
      cnt_nxt_s = (cnt_r == STABLE_L) ? STABLE_L : cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = 8'd1;
    end
    // A saturated counter on an unchanged sample is the tail of a run already captured.
    capture_s = onehot_s && (cnt_nxt_s == STABLE_L) && !(same_s && (cnt_r == STABLE_L));
    dec_s           = decode_seg(bus.seg_in);
    shd_bcd_nxt_s   = shd_bcd_r;
    shd_blank_nxt_s = shd_blank_r;
    shd_err_nxt_s   = shd_err_r;
    cap_nxt_s       = captured_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture_s && bus.dig_en[i]) begin
        shd_bcd_nxt_s[4*i +: 4] = dec_s[3:0];
        shd_blank_nxt_s[i]      = dec_s[4];
        shd_err_nxt_s[i]        = dec_s[5];
        cap_nxt_s[i]            = 1'b1;
      end else begin
        cap_nxt_s[i] = captured_r[i];
      end
    end
    complete_s  = &cap_nxt_s;
    handshake_s = (state_r == HOLD) && bus.frame_ready;
    tmo_hit_s   = (captured_r != {DIGITS{1'b0}}) && !capture_s && (tmo_r == TMO_LAST);
  end

  // Sample history, shadow slots, timeout and the COLLECT/HOLD frame FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= COLLECT;
      prev_r        <= {(DIGITS+7){1'b0}};
      cnt_r         <= 8'd0;
      tmo_r         <= 16'd0;
      captured_r    <= {DIGITS{1'b0}};
      shd_bcd_r     <= {(4*DIGITS){1'b0}};
      shd_blank_r   <= {DIGITS{1'b0}};
      shd_err_r     <= {DIGITS{1'b0}};
      frame_bcd_r   <= {(4*DIGITS){1'b0}};
      frame_blank_r <= {DIGITS{1'b0}};
      frame_err_r   <= {DIGITS{1'b0}};
      valid_r       <= 1'b0;
      overrun_r     <= 1'b0;
      abort_r       <= 1'b0;
    end else begin
      prev_r      <= sample_s;
      cnt_r       <= cnt_nxt_s;
      shd_bcd_r   <= shd_bcd_nxt_s;
      shd_blank_r <= shd_blank_nxt_s;
      shd_err_r   <= shd_err_nxt_s;
      overrun_r   <= 1'b0;
      abort_r     <= 1'b0;
      if (capture_s || (captured_r == {DIGITS{1'b0}})) begin
        tmo_r <= 16'd0;
      end else if (tmo_r == TMO_LAST) begin
        tmo_r <= 16'd0;
      end else begin
        tmo_r <= tmo_r + 16'd1;
      end
      if (complete_s) begin
        captured_r <= {DIGITS{1'b0}};
      end else if (tmo_hit_s) begin
        captured_r <= {DIGITS{1'b0}};
        abort_r    <= 1'b1;
      end else begin
        captured_r <= cap_nxt_s;
      end
      case (state_r)
        COLLECT: begin
          if (complete_s) begin
            frame_bcd_r   <= shd_bcd_nxt_s;
            frame_blank_r <= shd_blank_nxt_s;
            frame_err_r   <= shd_err_nxt_s;
            valid_r       <= 1'b1;
            state_r       <= HOLD;
          end else begin
            valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (complete_s && handshake_s) begin
            frame_bcd_r   <= shd_bcd_nxt_s;
            frame_blank_r <= shd_blank_nxt_s;
            frame_err_r   <= shd_err_nxt_s;
          end else if (complete_s) begin
            overrun_r <= 1'b1;
          end else if (handshake_s) begin
            valid_r <= 1'b0;
            state_r <= COLLECT;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= COLLECT;
        end
      endcase
    end
  end

  assign bus.frame_bcd   = frame_bcd_r;
  assign bus.frame_blank = frame_blank_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.frame_valid = valid_r;
  assign bus.overrun     = overrun_r;
  assign bus.frame_abort = abort_r;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed test-plan scenarios plus random scanning,
// compared every cycle against a frame-level behavioural model.
module tb_seg_scan_capture;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int TMO    = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;
  int abort_seen = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  seg_scan_capture_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CNT(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: sample history as a run length, slots, and expected outputs.
  logic [10:0] m_last;
  int          m_run;
  int          cyc;
  int          last_cap;
  logic [3:0]  m_capd;
  logic [15:0] sh_bcd;
  logic [3:0]  sh_blank, sh_err;
  logic [15:0] e_bcd;
  logic [3:0]  e_blank, e_err;
  logic        e_valid, e_ovr, e_abort;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdec(input logic [6:0] s, output logic [3:0] v, output logic b, output logic e);
    v = 4'hF; b = 1'b0; e = 1'b1;
    if (s == 7'b0000000) begin
      v = 4'h0; b = 1'b1; e = 1'b0;
    end else begin
      for (int k = 0; k < 10; k++)
        if (pat[k] == s) begin v = 4'(k); e = 1'b0; end
    end
  endtask

  task automatic model_step(input logic [3:0] de, input logic [6:0] sg, input logic rdy, input logic rstn);
    logic [10:0] s;
    logic cap, was_any, complete, tmo;
    logic [3:0] v;
    logic b, e;
    cyc++;
    if (!rstn) begin
      m_last = '0; m_run = 0; m_capd = '0; sh_bcd = '0; sh_blank = '0; sh_err = '0;
      e_bcd = '0; e_blank = '0; e_err = '0; e_valid = 1'b0; e_ovr = 1'b0; e_abort = 1'b0;
      last_cap = cyc;
    end else begin
      s = {de, sg};
      if ($countones(de) != 1) m_run = 0;
      else if (s == m_last) m_run++;
      else m_run = 1;
      m_last = s;
      cap = ($countones(de) == 1) && (m_run == STABLE);
      was_any = |m_capd;
      e_ovr = 1'b0; e_abort = 1'b0;
      if (cap) begin
        mdec(sg, v, b, e);
        for (int d = 0; d < DIGITS; d++)
          if (de[d]) begin
            sh_bcd[4*d +: 4] = v; sh_blank[d] = b; sh_err[d] = e; m_capd[d] = 1'b1;
          end
        last_cap = cyc;
      end
      complete = &m_capd;
      tmo = !cap && was_any && (cyc - last_cap == TMO);
      if (complete) m_capd = '0;
      else if (tmo) begin m_capd = '0; e_abort = 1'b1; end
      if (complete && (!e_valid || rdy)) begin
        e_bcd = sh_bcd; e_blank = sh_blank; e_err = sh_err; e_valid = 1'b1;
      end else if (complete) begin
        e_ovr = 1'b1;
      end else if (e_valid && rdy) begin
        e_valid = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic [3:0] de, input logic [6:0] sg, input logic rdy);
    bus.dig_en = de; bus.seg_in = sg; bus.frame_ready = rdy;
    @(posedge clk);
    model_step(de, sg, rdy, rst_n);
    @(negedge clk);
  endtask

  task automatic scan(input logic [3:0] de, input logic [6:0] sg, input int n, input logic rdy);
    for (int k = 0; k < n; k++) tick(de, sg, rdy);
  endtask

  task automatic full_frame(input int d0, input int d1, input int d2, input int d3, input logic rdy);
    scan(4'b0001, pat[d0], 6, rdy);
    scan(4'b0010, pat[d1], 6, rdy);
    scan(4'b0100, pat[d2], 6, rdy);
    scan(4'b1000, pat[d3], 6, rdy);
  endtask

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_valid", {15'd0, bus.frame_valid}, {15'd0, e_valid});
      chk("frame_bcd", bus.frame_bcd, e_bcd);
      chk("frame_blank", {12'd0, bus.frame_blank}, {12'd0, e_blank});
      chk("frame_err", {12'd0, bus.frame_err}, {12'd0, e_err});
      chk("overrun", {15'd0, bus.overrun}, {15'd0, e_ovr});
      chk("frame_abort", {15'd0, bus.frame_abort}, {15'd0, e_abort});
      if (bus.overrun) ovr_seen++;
      if (bus.frame_abort) abort_seen++;
    end
  end

  initial begin
    int o0, a0, hold, r;
    logic [3:0] de;
    logic [6:0] sg, gl;
    cyc = 0;
    bus.dig_en = '0; bus.seg_in = '0; bus.frame_ready = 1'b0;
    rst_n = 1'b0;
    tick(4'b0000, 7'd0, 1'b0);
    chk_en = 1'b1;
    tick(4'b0000, 7'd0, 1'b0);
    #1 chk("reset_valid", {15'd0, bus.frame_valid}, 16'd0);
    chk("reset_bcd", bus.frame_bcd, 16'd0);
    rst_n = 1'b1;

    // Frame 0123 and exact completion latency.
    scan(4'b0001, pat[3], 6, 1'b0);
    scan(4'b0010, pat[2], 6, 1'b0);
    scan(4'b0100, pat[1], 6, 1'b0);
    scan(4'b1000, pat[0], 3, 1'b0);
    #1 chk("lat_before", {15'd0, bus.frame_valid}, 16'd0);
    scan(4'b1000, pat[0], 1, 1'b0);
    #1 chk("lat_valid", {15'd0, bus.frame_valid}, 16'd1);
    chk("bcd_0123", bus.frame_bcd, 16'h0123);
    chk("model_0123", e_bcd, 16'h0123);
    chk("blank_err_0", {8'd0, bus.frame_blank, bus.frame_err}, 16'd0);
    scan(4'b1000, pat[0], 1, 1'b1);
    #1 chk("hs_drop", {15'd0, bus.frame_valid}, 16'd0);

    // Blank and illegal digits.
    scan(4'b0001, pat[5], 6, 1'b0);
    scan(4'b0010, 7'b0000000, 6, 1'b0);
    scan(4'b0100, 7'b1001001, 6, 1'b0);
    scan(4'b1000, pat[7], 6, 1'b0);
    #1 chk("bcd_err", bus.frame_bcd, 16'h7F05);
    chk("err_mask", {12'd0, bus.frame_err}, 16'h0004);
    chk("blank_mask", {12'd0, bus.frame_blank}, 16'h0002);
    tick(4'b1000, pat[7], 1'b1);

    // Invalid dig_en gap and a one-sample glitch.
    scan(4'b0001, pat[4], 6, 1'b0);
    scan(4'b0110, pat[8], 20, 1'b0);
    scan(4'b0010, pat[8], 2, 1'b0);
    scan(4'b0010, pat[8] ^ 7'b0000100, 1, 1'b0);
    scan(4'b0010, pat[8], 6, 1'b0);
    scan(4'b0100, pat[6], 6, 1'b0);
    scan(4'b1000, pat[9], 6, 1'b0);
    #1 chk("bcd_glitch", bus.frame_bcd, 16'h9684);

    // Overrun while held, then a same-cycle handshake reload.
    o0 = ovr_seen;
    full_frame(1, 1, 1, 1, 1'b0);
    #1 chk("ovr_once", 16'(ovr_seen - o0), 16'd1);
    chk("ovr_keep", bus.frame_bcd, 16'h9684);
    scan(4'b0001, pat[2], 6, 1'b0);
    scan(4'b0010, pat[4], 6, 1'b0);
    scan(4'b0100, pat[6], 6, 1'b0);
    scan(4'b1000, pat[8], 3, 1'b0);
    scan(4'b1000, pat[8], 1, 1'b1);
    #1 chk("reload_valid", {15'd0, bus.frame_valid}, 16'd1);
    chk("reload_bcd", bus.frame_bcd, 16'h8642);
    chk("reload_ovr", 16'(ovr_seen - o0), 16'd1);
    tick(4'b1000, pat[8], 1'b1);

    // Partial frame timeout.
    a0 = abort_seen;
    scan(4'b0001, pat[1], 6, 1'b0);
    scan(4'b0010, pat[2], 6, 1'b0);
    scan(4'b0000, 7'd0, 47, 1'b0);
    #1 chk("abort_early", {15'd0, bus.frame_abort}, 16'd0);
    scan(4'b0000, 7'd0, 1, 1'b0);
    #1 chk("abort_pulse", {15'd0, bus.frame_abort}, 16'd1);
    scan(4'b0000, 7'd0, 10, 1'b0);
    chk("abort_once", 16'(abort_seen - a0), 16'd1);
    full_frame(0, 8, 5, 2, 1'b0);
    #1 chk("post_abort", bus.frame_bcd, 16'h2580);

    // Reset while holding a frame.
    rst_n = 1'b0;
    tick(4'b1000, pat[2], 1'b0);
    #1 chk("rst_valid", {15'd0, bus.frame_valid}, 16'd0);
    chk("rst_bcd", bus.frame_bcd, 16'd0);
    rst_n = 1'b1;
    full_frame(9, 7, 3, 1, 1'b0);
    #1 chk("post_rst", bus.frame_bcd, 16'h1379);
    tick(4'b0000, 7'd0, 1'b1);

    // Random scanning with random ready, glitches, gaps and rare resets.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 39);
      hold = $urandom_range(1, 8);
      if (r == 0) begin
        de = 4'($urandom_range(0, 15));
      end else if (r == 1) begin
        de = 4'b0000;
        hold = $urandom_range(30, 70);
      end else begin
        de = 4'b0001 << $urandom_range(0, 3);
      end
      r = $urandom_range(0, 11);
      if (r < 10) sg = pat[r];
      else if (r == 10) sg = 7'd0;
      else sg = 7'($urandom_range(0, 127));
      for (int h = 0; h < hold; h++) begin
        gl = ($urandom_range(0, 15) == 0) ? (sg ^ 7'b0010000) : sg;
        tick(de, gl, ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        tick(de, sg, 1'b0);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Reader for a time-multiplexed 7-segment display bus: one-hot digit enable plus segment lines a..g.
- Samples the bus and accepts a segment pattern only once it has been stable for a set number of cycles.
- Converts each accepted pattern back to BCD and assembles a full multi-digit frame.
- Delivers each frame over a valid/ready handshake. Used as the stopwatch display checker and for display loop-back capture.

Parameters:
- DIGITS, 4, number of multiplexed digits; width of dig_en and digit slot count.
- STABLE_CNT, 4, consecutive identical samples required before a pattern is accepted (legal range 1..255).
- TIMEOUT, 1000, cycles without a new capture after which a partial frame is discarded (legal range 2..65535).

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg_in  input  7  segment lines, active high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_en  input  DIGITS  digit enable; must be one-hot to be valid; bit i selects digit i, digit 0 is least significant.
- frame_bcd  output  4*DIGITS  captured frame; nibble i is digit i.
- frame_blank  output  DIGITS  bit i set when digit i was all segments off.
- frame_err  output  DIGITS  bit i set when digit i was an illegal pattern.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts the frame.
- overrun  output  1  one-cycle pulse: a complete frame was dropped.
- frame_abort  output  1  one-cycle pulse: a partial frame timed out.

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs 0, stability counter 0, previous-sample register 0, shadow slots and captured mask cleared, timeout counter 0, state COLLECT.
- Decode table, {a..g} to BCD:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - 0000000: nibble 0, blank=1.
  - Any other pattern: nibble F, err=1.
- Stability check, every cycle:
  - If dig_en is not one-hot (zero or several bits set): stability counter forced to 0, no capture.
  - Else if {dig_en,seg_in} equals the previous cycle's sample: counter increments, saturating at STABLE_CNT.
  - Else: counter loads 1.
  - Capture happens on the cycle the counter transitions to STABLE_CNT, so at most once per stable run. The decoded nibble, blank and err flags are written to shadow slot i and captured[i] is set.
  - With STABLE_CNT=1, every change of one-hot sample captures.
  - Recapturing a slot that is already marked captured overwrites it.
- Frame completion: captured mask all ones at end of a cycle.
  - Shadow slots copy to frame_bcd, frame_blank and frame_err; frame_valid=1 from the next cycle; captured mask clears.
  - Latency: frame_valid rises exactly 1 cycle after the completing capture.
- State COLLECT: frame_valid=0. Frame completion moves to HOLD.
- State HOLD: frame_valid=1 and the frame outputs are held stable. Capture into the shadow slots continues.
  - frame_valid & frame_ready: handshake completes; next cycle frame_valid=0, state COLLECT.
  - Shadow completes in the same cycle as the handshake: the new frame loads directly, frame_valid stays 1, state stays HOLD, no overrun.
  - Shadow completes with no handshake: overrun pulses for 1 cycle, shadow frame discarded, captured mask cleared, output frame unchanged.
- Timeout:
  - The 16-bit counter clears on every capture and whenever the captured mask is zero; otherwise it increments.
  - At TIMEOUT: captured mask clears, frame_abort pulses for 1 cycle, counter clears. Timeout is active in both states.
- Reset mid-frame or mid-HOLD: the pending frame is lost, frame_valid drops immediately after the reset edge, no pulse outputs.

Test Plan:
- Reset then scan digits 0..3 with 3,2,1,0 (dig_en 0001..1000), each held 6 cycles, STABLE_CNT=4 -> frame_bcd=16'h0123, frame_valid rises 1 cycle after digit 3's 4th stable sample, blank=0, err=0.
- Hold digit 2 with pattern 1001001, others valid -> frame_err=0100, nibble 2=F; digit 1 at 0000000 -> frame_blank=0010, nibble 1=0.
- Hold dig_en=0110 for 20 cycles between digits, and glitch a segment on cycle 3 of a 4-cycle window -> no capture until 4 clean samples; frame contents correct.
- frame_ready=0 while a second full frame is scanned -> overrun single pulse, frame_bcd unchanged; assert ready on the cycle the third frame completes -> frame_valid stays 1, new data, no overrun.
- Capture digits 0 and 1 only, then idle with TIMEOUT=50 -> frame_abort pulses at 50 cycles after last capture; a following full scan yields a clean frame.
- Assert rst_n=0 for 1 cycle while in HOLD -> all outputs 0 next cycle, state COLLECT, subsequent scan captured normally.
